rx_matrix_loader: RTL and testbench

Consumes received UART frames from the receiver stage and unpacks them into the two operand matrices of the matrix multiplier. A load starts with a sync byte, followed by N×N elements of matrix A then N×N elements of matrix B, row-major. Each element is written through a single write port into the operand buffers. The block then holds `matrices_ready` until the multiplier acknowledges. It sits directly downstream of the UART receiver's `rx_status`/`rx_output` pair.

---
 rtl/rx_matrix_loader.sv | 99 +++++++++
 tb/tb_rx_matrix_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_matrix_loader.sv
// rx_matrix_loader: unpacks sync-prefixed UART frames into operand matrices A and B via a single write port
module rx_matrix_loader #(
  parameter int N = 2,
  parameter int TIMEOUT = 20000,
  parameter logic [7:0] SYNC = 8'hA5,
  parameter int AW = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_status,
  input  logic [9:0]    rx_output,
  input  logic          mat_ack,
  input  logic          err_clr,
  output logic          wr_en,
  output logic          wr_sel,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          matrices_ready,
  output logic          frame_err,
  output logic          timeout_err,
  output logic          overrun
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, READY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d, wr_addr_q, wr_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] wr_data_q, wr_data_d, rx_byte;
  logic wr_en_q, wr_en_d, wr_sel_q, wr_sel_d, ready_q, ready_d;
  logic frame_err_q, frame_err_d, timeout_err_q, timeout_err_d, overrun_q, overrun_d;
  logic valid, loading, last, tmo;
  always_comb begin
    valid = !rx_output[0] && rx_output[9];
    rx_byte = rx_output[8:1];
    loading = state_q == LOAD_A || state_q == LOAD_B;
    last = idx_q == AW'(N * N - 1);
    tmo = loading && !rx_status && cnt_q == CW'(TIMEOUT - 1);
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = (loading && !rx_status && !tmo) ? cnt_q + 1'b1 : '0;
    wr_en_d = loading && rx_status && valid;
    wr_sel_d = wr_en_d ? state_q == LOAD_B : wr_sel_q;
    wr_addr_d = wr_en_d ? idx_q : wr_addr_q;
    wr_data_d = wr_en_d ? rx_byte : wr_data_q;
    ready_d = state_q == READY && !mat_ack;
    frame_err_d = (rx_status && !valid) || (frame_err_q && !err_clr);
    timeout_err_d = tmo || (timeout_err_q && !err_clr);
    overrun_d = (rx_status && state_q == READY) || (overrun_q && !err_clr);
    case (state_q)
      IDLE: if (rx_status && valid && rx_byte == SYNC) begin
        state_d = LOAD_A;
        idx_d = '0;
      end
      LOAD_A, LOAD_B: if ((rx_status && !valid) || tmo) begin
        state_d = IDLE;
        idx_d = '0;
      end else if (wr_en_d) begin
        idx_d = last ? '0 : idx_q + 1'b1;
        state_d = !last ? state_q : state_q == LOAD_A ? LOAD_B : READY;
      end
      READY: state_d = mat_ack ? IDLE : READY;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      wr_en_q <= 1'b0;
      wr_sel_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ready_q <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      wr_en_q <= wr_en_d;
      wr_sel_q <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q <= ready_d;
      frame_err_q <= frame_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_q <= overrun_d;
    end
  assign wr_en = wr_en_q;
  assign wr_sel = wr_sel_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign matrices_ready = ready_q;
  assign frame_err = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_rx_matrix_loader.sv
// tb_rx_matrix_loader: directed self-checking bench for rx_matrix_loader
module tb_rx_matrix_loader;
  logic clk = 1'b0, rst, rx_status, mat_ack, err_clr;
  logic [9:0] rx_output;
  logic wr_en, wr_sel, matrices_ready, frame_err, timeout_err, overrun;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [10:0] wq[$];
  int checks = 0, errors = 0;
  rx_matrix_loader #(.N(2), .TIMEOUT(50), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_status(rx_status), .rx_output(rx_output),
    .mat_ack(mat_ack), .err_clr(err_clr), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .matrices_ready(matrices_ready),
    .frame_err(frame_err), .timeout_err(timeout_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (wr_en) wq.push_back({wr_sel, wr_addr, wr_data});
  task automatic send(input logic [7:0] b, input logic stop = 1'b1);
    rx_status = 1'b1;
    rx_output = {stop, b, 1'b0};
    @(posedge clk);
    #1 rx_status = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_ack();
    mat_ack = 1'b1;
    @(posedge clk);
    #1 mat_ack = 1'b0;
  endtask
  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    wq.delete();
  endtask
  task automatic full_load();
    send(8'hA5);
    for (int i = 1; i <= 8; i++) send(8'(i));
  endtask
  task automatic check_nominal_writes(input string name);
    checks++;
    if (wq.size() !== 8) begin
      errors++;
      $display("FAIL %s count got %0d exp 8", name, wq.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [10:0] exp;
      exp = {i >= 4, 2'(i % 4), 8'(i + 1)};
      checks++;
      if (wq[i] !== exp) begin
        errors++;
        $display("FAIL %s write%0d got %h exp %h", name, i, wq[i], exp);
      end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    rx_status = 1'b0;
    rx_output = '0;
    mat_ack = 1'b0;
    err_clr = 1'b0;
    idle(2);
    checks++;
    if ({wr_en, wr_sel, wr_addr, wr_data, matrices_ready, frame_err, timeout_err, overrun} !== 16'h0) begin
      errors++;
      $display("FAIL reset outputs got %h exp 0", {wr_en, wr_sel, wr_addr, wr_data, matrices_ready, frame_err, timeout_err, overrun});
    end
    rst = 1'b0;
    idle(1);
  endtask
  task automatic test_nominal();
    do_reset();
    full_load();
    @(negedge clk);
    checks++;
    if (matrices_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_early got %b exp 0", matrices_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (matrices_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise got %b exp 1", matrices_ready);
    end
    pulse_ack();
    checks++;
    if (matrices_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_ack got %b exp 0", matrices_ready);
    end
    check_nominal_writes("nominal");
    checks++;
    if ({frame_err, timeout_err, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL nominal_errs got %b exp 000", {frame_err, timeout_err, overrun});
    end
  endtask
  task automatic test_idle_filter();
    do_reset();
    send(8'h00);
    send(8'h5A);
    send(8'hFF);
    idle(2);
    checks++;
    if (wq.size() !== 0 || {frame_err, timeout_err, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL idle_filter got writes %0d errs %b exp 0 000", wq.size(), {frame_err, timeout_err, overrun});
    end
    full_load();
    idle(2);
    checks++;
    if (matrices_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_filter_ready got %b exp 1", matrices_ready);
    end
    check_nominal_writes("idle_filter");
    pulse_ack();
  endtask
  task automatic test_frame_err();
    do_reset();
    send(8'hA5);
    send(8'h11);
    send(8'h22);
    send(8'h33, 1'b0);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frame_err_set got %b exp 1", frame_err);
    end
    send(8'h44);
    idle(2);
    checks++;
    if (wq.size() !== 2) begin
      errors++;
      $display("FAIL frame_idle writes got %0d exp 2", wq.size());
    end
    send(8'hA5);
    send(8'h55);
    idle(2);
    checks++;
    if (wq.size() !== 3 || wq[2] !== {1'b0, 2'd0, 8'h55}) begin
      errors++;
      $display("FAIL frame_restart got n=%0d last %h exp n=3 %h", wq.size(), wq[wq.size()-1], {1'b0, 2'd0, 8'h55});
    end
    pulse_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_clr got %b exp 0", frame_err);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    send(8'hA5);
    send(8'h01);
    idle(49);
    send(8'h02);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_49 got %b exp 0", timeout_err);
    end
    idle(49);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got %b exp 0", timeout_err);
    end
    idle(1);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_50 got %b exp 1", timeout_err);
    end
    send(8'h05);
    idle(2);
    checks++;
    if (wq.size() !== 2) begin
      errors++;
      $display("FAIL timeout_idle writes got %0d exp 2", wq.size());
    end
    pulse_clr();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clr got %b exp 0", timeout_err);
    end
  endtask
  task automatic test_overrun();
    do_reset();
    full_load();
    idle(2);
    wq.delete();
    send(8'h33);
    idle(3);
    checks++;
    if ({wq.size() == 0, overrun, matrices_ready} !== 3'b111) begin
      errors++;
      $display("FAIL overrun got nowrite/ov/ready %b exp 111", {wq.size() == 0, overrun, matrices_ready});
    end
    pulse_ack();
    checks++;
    if (matrices_ready !== 1'b0) begin
      errors++;
      $display("FAIL overrun_ack got %b exp 0", matrices_ready);
    end
    pulse_clr();
    full_load();
    idle(2);
    mat_ack = 1'b1;
    send(8'h77);
    mat_ack = 1'b0;
    idle(1);
    checks++;
    if ({overrun, matrices_ready} !== 2'b10) begin
      errors++;
      $display("FAIL overrun_ack_same got ov/ready %b exp 10", {overrun, matrices_ready});
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_en, wr_sel, wr_addr, wr_data, matrices_ready, frame_err, timeout_err, overrun} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid got %h exp 0", {wr_en, wr_sel, wr_addr, wr_data, matrices_ready, frame_err, timeout_err, overrun});
    end
    idle(1);
    rst = 1'b0;
    idle(1);
    wq.delete();
    full_load();
    idle(2);
    check_nominal_writes("reset_mid");
    pulse_ack();
  endtask
  initial begin
    test_reset();
    test_nominal();
    test_idle_filter();
    test_frame_err();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
